packet_rr_arbiter: RTL and testbench

//  Packet-atomic round-robin arbiter merging NUM_PORTS AXI4-Stream inputs (typically 64-bit

---
 rtl/packet_rr_arbiter.sv | 129 ++++++++++++
 tb/tb_packet_rr_arbiter.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_rr_arbiter.sv
// Packet-atomic round-robin arbiter.
// Merges NUM_PORTS AXI4-Stream inputs onto one output. A granted port keeps the
// output until its tlast beat handshakes. The data path is purely combinational,
// and m_src_port tags every beat with the index of the port that sent it.
module packet_rr_arbiter #(
  parameter int DATA_WIDTH    = 64,
  parameter int NUM_PORTS     = 4,
  parameter int PORT_ID_WIDTH = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_PORTS-1:0]              port_enable,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic [NUM_PORTS-1:0]              s_axis_tuser,
  input  logic [NUM_PORTS-1:0]              s_axis_tlast,
  input  logic [NUM_PORTS-1:0]              s_axis_tvalid,
  output logic [NUM_PORTS-1:0]              s_axis_tready,
  output logic [DATA_WIDTH-1:0]             m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]           m_axis_tkeep,
  output logic                              m_axis_tuser,
  output logic                              m_axis_tlast,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic [PORT_ID_WIDTH-1:0]          m_src_port
);

  localparam int KEEP_WIDTH = DATA_WIDTH / 8;
  localparam logic [PORT_ID_WIDTH-1:0] LAST_PORT = PORT_ID_WIDTH'(NUM_PORTS - 1);
  localparam logic [PORT_ID_WIDTH-1:0] ONE       = PORT_ID_WIDTH'(1);

  typedef enum logic {
    IDLE,
    PKT
  } state_t;

  state_t                   state;
  state_t                   state_next;
  logic [PORT_ID_WIDTH-1:0] grant;
  logic [PORT_ID_WIDTH-1:0] grant_next;
  logic [PORT_ID_WIDTH-1:0] last_grant;
  logic [PORT_ID_WIDTH-1:0] last_grant_next;
  logic [PORT_ID_WIDTH-1:0] pick;
  logic [PORT_ID_WIDTH-1:0] search_idx;
  logic                     pick_found;
  logic [NUM_PORTS-1:0]     candidates;
  logic                     packet_done;

  logic [DATA_WIDTH-1:0]    port_data [NUM_PORTS];
  logic [KEEP_WIDTH-1:0]    port_keep [NUM_PORTS];

  // Split the flat per-port buses into arrays so the grant can index them directly.
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_unpack
    assign port_data[i] = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
    assign port_keep[i] = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
  end

  assign candidates  = s_axis_tvalid & port_enable;
  assign packet_done = m_axis_tvalid & m_axis_tready & m_axis_tlast;

  // Round-robin search: the first candidate after last_grant, wrapping at the top port.
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    search_idx = last_grant;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (search_idx == LAST_PORT) begin
        search_idx = '0;
      end else begin
        search_idx = search_idx + ONE;
      end
      if (!pick_found && candidates[search_idx]) begin
        pick_found = 1'b1;
        pick       = search_idx;
      end
    end
  end

  // State register: a synchronous reset makes port 0 the first winner.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= LAST_PORT;
    end else begin
      state      <= state_next;
      grant      <= grant_next;
      last_grant <= last_grant_next;
    end
  end

  // Next state: arbitrate in IDLE; release the output only on a tlast handshake.
  always_comb begin
    state_next      = state;
    grant_next      = grant;
    last_grant_next = last_grant;
    case (state)
      IDLE: begin
        if (pick_found) begin
          grant_next = pick;
          state_next = PKT;
        end
      end
      PKT: begin
        if (packet_done) begin
          last_grant_next = grant;
          state_next      = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs: a zero-latency mux from the granted port; nothing moves while IDLE.
  always_comb begin
    m_axis_tdata  = port_data[grant];
    m_axis_tkeep  = port_keep[grant];
    m_axis_tuser  = s_axis_tuser[grant];
    m_axis_tlast  = s_axis_tlast[grant];
    m_src_port    = grant;
    m_axis_tvalid = 1'b0;
    s_axis_tready = '0;
    if (state == PKT) begin
      m_axis_tvalid        = s_axis_tvalid[grant];
      s_axis_tready[grant] = m_axis_tready;
    end
  end

endmodule

// File: tb/tb_packet_rr_arbiter.sv
// Testbench for packet_rr_arbiter.
// Each port is fed from a beat store that the bench fills. A transaction-level
// reference model tracks which port owns the output, applies the round-robin
// rule arithmetically, and checks every beat against the head of its source store.
module tb_packet_rr_arbiter;

  localparam int DW = 64;
  localparam int KW = DW / 8;
  localparam int NP = 4;
  localparam int PW = 2;
  localparam int QD = 64;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          user;
    logic          last;
  } beat_t;

  logic             clk;
  logic             reset;
  logic [NP-1:0]    port_enable;
  logic [NP*DW-1:0] s_tdata;
  logic [NP*KW-1:0] s_tkeep;
  logic [NP-1:0]    s_tuser;
  logic [NP-1:0]    s_tlast;
  logic [NP-1:0]    s_tvalid;
  logic [NP-1:0]    s_tready;
  logic [DW-1:0]    m_tdata;
  logic [KW-1:0]    m_tkeep;
  logic             m_tuser;
  logic             m_tlast;
  logic             m_tvalid;
  logic             m_tready;
  logic [PW-1:0]    m_src;

  beat_t mem [NP][QD];
  int    head [NP];
  int    tail [NP];

  int            n_assert;
  int            n_fail;
  int            cycle;
  int            serial;
  logic [NP-1:0] hold;
  int            gap_pct;
  int            ready_mode;
  int            owner;
  int            last_served;
  int            pick_next;
  bit            hs;
  int            order [$];
  int            beats_out;
  int            beats_pushed;

  packet_rr_arbiter #(
    .DATA_WIDTH   (DW),
    .NUM_PORTS    (NP),
    .PORT_ID_WIDTH(PW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .port_enable  (port_enable),
    .s_axis_tdata (s_tdata),
    .s_axis_tkeep (s_tkeep),
    .s_axis_tuser (s_tuser),
    .s_axis_tlast (s_tlast),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .m_axis_tdata (m_tdata),
    .m_axis_tkeep (m_tkeep),
    .m_axis_tuser (m_tuser),
    .m_axis_tlast (m_tlast),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .m_src_port   (m_src)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Round-robin rule: the first requesting port after the last one served, modulo NP.
  function automatic int rr_pick(logic [NP-1:0] cand, int last);
    for (int k = 1; k <= NP; k++) begin
      if (cand[(last + k) % NP]) return (last + k) % NP;
    end
    return -1;
  endfunction

  function automatic int pending(logic [NP-1:0] mask);
    int n = 0;
    for (int p = 0; p < NP; p++) if (mask[p]) n += tail[p] - head[p];
    return n;
  endfunction

  function automatic logic [63:0] order_code();
    logic [63:0] c = '0;
    foreach (order[i]) c = (c << 4) | 64'(order[i]);
    return c;
  endfunction

  task automatic push_pkt(input int p, input int n, input bit fixed_keep, input logic [KW-1:0] keep);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.data = {8'(p), 24'(serial), 32'($urandom)};
      b.keep = fixed_keep ? keep : KW'($urandom);
      b.user = 1'($urandom_range(1));
      b.last = (i == n - 1);
      mem[p][tail[p]] = b;
      tail[p]++;
      serial++;
      beats_pushed++;
    end
  endtask

  // Upstream and model both return to their reset state.
  task automatic flush_all();
    for (int p = 0; p < NP; p++) begin
      head[p] = 0;
      tail[p] = 0;
    end
    owner       = -1;
    last_served = NP - 1;
  endtask

  task automatic apply_stimulus();
    beat_t b;
    for (int p = 0; p < NP; p++) begin
      if (head[p] < tail[p]) begin
        b = mem[p][head[p]];
        s_tvalid[p] = !hold[p] && ($urandom_range(99) >= gap_pct);
      end else begin
        b.data = {$urandom, $urandom};
        b.keep = KW'($urandom);
        b.user = 1'($urandom_range(1));
        b.last = 1'($urandom_range(1));
        s_tvalid[p] = 1'b0;
      end
      s_tdata[p*DW +: DW] = b.data;
      s_tkeep[p*KW +: KW] = b.keep;
      s_tuser[p]          = b.user;
      s_tlast[p]          = b.last;
    end
    case (ready_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = (cycle % 2 == 0);
      default: m_tready = 1'($urandom_range(1));
    endcase
  endtask

  task automatic check_output();
    beat_t b;
    hs        = 1'b0;
    pick_next = -1;
    if (owner < 0) begin
      check("idle_tvalid", 64'(m_tvalid), 64'd0);
      check("idle_tready", 64'(s_tready), 64'd0);
      pick_next = rr_pick(s_tvalid & port_enable, last_served);
    end else begin
      check("pkt_tvalid", 64'(m_tvalid), 64'(s_tvalid[owner]));
      check("pkt_tready", 64'(s_tready), m_tready ? (64'd1 << owner) : 64'd0);
      if (s_tvalid[owner]) begin
        b = mem[owner][head[owner]];
        check("beat_data", m_tdata, b.data);
        check("beat_keep", 64'(m_tkeep), 64'(b.keep));
        check("beat_user", 64'(m_tuser), 64'(b.user));
        check("beat_last", 64'(m_tlast), 64'(b.last));
        check("beat_src", 64'(m_src), 64'(owner));
        hs = m_tready;
      end
    end
  endtask

  task automatic advance_model();
    beat_t b;
    if (hs) begin
      b = mem[owner][head[owner]];
      head[owner]++;
      if (head[owner] == tail[owner]) begin
        head[owner] = 0;
        tail[owner] = 0;
      end
      beats_out++;
      if (b.last) begin
        last_served = owner;
        owner       = -1;
      end
    end else if (pick_next >= 0) begin
      owner = pick_next;
      order.push_back(pick_next);
    end
  endtask

  // One clock: drive after the edge, check at the falling edge, update the model after the next edge.
  task automatic step();
    apply_stimulus();
    @(negedge clk);
    check_output();
    @(posedge clk);
    #1;
    advance_model();
    cycle++;
  endtask

  task automatic drain(input logic [NP-1:0] mask, input int budget, output int used);
    used = 0;
    while (pending(mask) != 0 && used < budget) begin
      step();
      used++;
    end
    check("drain_left", 64'(pending(mask)), 64'd0);
  endtask

  initial begin
    int used;
    int b0;
    int p0;

    n_assert     = 0;
    n_fail       = 0;
    cycle        = 0;
    serial       = 0;
    beats_out    = 0;
    beats_pushed = 0;
    hold         = '0;
    gap_pct      = 0;
    ready_mode   = 0;
    port_enable  = '1;
    reset        = 1'b1;
    s_tvalid     = '0;
    s_tdata      = '0;
    s_tkeep      = '0;
    s_tuser      = '0;
    s_tlast      = '0;
    m_tready     = 1'b0;
    flush_all();

    // Reset held with a port requesting: nothing may be offered or accepted.
    repeat (2) @(posedge clk);
    #1;
    push_pkt(1, 2, 0, '0);
    apply_stimulus();
    @(negedge clk);
    check("reset_tvalid", 64'(m_tvalid), 64'd0);
    check("reset_tready", 64'(s_tready), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    flush_all();

    // 1: all ports busy with 3-beat packets -> 0,1,2,3,0 with one idle cycle each.
    $display("[TB] test 1: round robin over all ports");
    order.delete();
    for (int p = 0; p < NP; p++) push_pkt(p, 3, 0, '0);
    push_pkt(0, 3, 0, '0);
    drain(4'hF, 100, used);
    check("t1_cycles", 64'(used), 64'd20);
    check("t1_npkts", 64'(order.size()), 64'd5);
    check("t1_order", order_code(), 64'h01230);

    // 2: port 2 with a toggling downstream ready.
    $display("[TB] test 2: stalls on port 2");
    order.delete();
    ready_mode = 1;
    b0 = beats_out;
    push_pkt(2, 5, 0, '0);
    drain(4'hF, 100, used);
    check("t2_beats", 64'(beats_out - b0), 64'd5);
    check("t2_order", order_code(), 64'h2);
    ready_mode = 0;

    // 3: port 1 pauses mid-packet while port 3 waits.
    $display("[TB] test 3: tvalid gap holds the grant");
    order.delete();
    push_pkt(1, 6, 0, '0);
    repeat (3) step();
    push_pkt(3, 3, 0, '0);
    hold[1] = 1'b1;
    repeat (4) step();
    hold[1] = 1'b0;
    drain(4'hF, 100, used);
    check("t3_npkts", 64'(order.size()), 64'd2);
    check("t3_order", order_code(), 64'h13);

    // 4: port 2 masked off; then port 1 disabled while it owns the output.
    $display("[TB] test 4: port_enable masking");
    order.delete();
    port_enable = 4'b1011;
    for (int p = 0; p < NP; p++) begin
      push_pkt(p, 2, 0, '0);
      push_pkt(p, 2, 0, '0);
    end
    drain(4'b1011, 200, used);
    check("t4_npkts", 64'(order.size()), 64'd6);
    check("t4_order", order_code(), 64'h013013);
    beats_pushed -= tail[2] - head[2];
    head[2] = 0;
    tail[2] = 0;
    order.delete();
    b0 = beats_out;
    push_pkt(1, 4, 0, '0);
    repeat (2) step();
    port_enable = 4'b1001;
    drain(4'b0010, 100, used);
    check("t4b_beats", 64'(beats_out - b0), 64'd4);
    check("t4b_order", order_code(), 64'h1);
    port_enable = 4'hF;

    // 5: single-beat packets with a partial keep on ports 0 and 3.
    $display("[TB] test 5: single-beat packets");
    order.delete();
    push_pkt(3, 1, 1, 8'h0F);
    drain(4'hF, 20, used);
    check("t5_prime", order_code(), 64'h3);
    order.delete();
    push_pkt(0, 1, 1, 8'h0F);
    push_pkt(0, 1, 1, 8'h0F);
    push_pkt(3, 1, 1, 8'h0F);
    push_pkt(3, 1, 1, 8'h0F);
    drain(4'hF, 50, used);
    check("t5_cycles", 64'(used), 64'd8);
    check("t5_order", order_code(), 64'h0303);

    // 6: reset in the middle of a port 1 packet.
    $display("[TB] test 6: reset mid-packet");
    order.delete();
    push_pkt(1, 5, 0, '0);
    repeat (3) step();
    check("t6_owner", 64'(owner), 64'd1);
    apply_stimulus();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    flush_all();
    order.delete();
    push_pkt(0, 2, 0, '0);
    push_pkt(1, 2, 0, '0);
    drain(4'hF, 50, used);
    check("t6_order", order_code(), 64'h01);

    // Random traffic: random packets, gaps, ready and enables.
    $display("[TB] random traffic");
    gap_pct    = 25;
    ready_mode = 2;
    b0 = beats_out;
    p0 = beats_pushed;
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < NP; p++) begin
        if (head[p] == tail[p] && $urandom_range(9) == 0) push_pkt(p, $urandom_range(1, 6), 0, '0);
      end
      if (c % 25 == 0) port_enable = 4'($urandom_range(1, 15));
      step();
    end
    port_enable = 4'hF;
    gap_pct     = 0;
    ready_mode  = 0;
    drain(4'hF, 500, used);
    check("rand_beats", 64'(beats_out - b0), 64'(beats_pushed - p0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
